// File: rtl/mem_pkg.sv
// Shared types for the data-memory interface: request/response payloads and
// the doubleword index helper.
package mem_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned LDTAG_W = 4;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [LDTAG_W-1:0] tag;
  } ld_req_t;

  typedef struct packed {
    logic [LDTAG_W-1:0] tag;
    logic [DATA_W-1:0]  data;
    logic               err;
  } ld_resp_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } st_req_t;

  // Doubleword index of a byte address; callers truncate to their array depth.
  function automatic logic [ADDR_W-4:0] dw_index(input logic [ADDR_W-1:0] addr);
    return (ADDR_W-3)'(addr >> 3);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core-to-scratchpad data-memory interface: load request/response and store channels.
interface dmem_responder_if;
  import mem_pkg::*;

  logic               ld_valid;
  logic               ld_ready;
  logic [ADDR_W-1:0]  ld_addr;
  logic [LDTAG_W-1:0] ld_tag;
  logic               ld_resp_valid;
  logic               ld_resp_ready;
  logic [LDTAG_W-1:0] ld_resp_tag;
  logic [DATA_W-1:0]  ld_resp_data;
  logic               ld_resp_err;
  logic               st_valid;
  logic               st_ready;
  logic [ADDR_W-1:0]  st_addr;
  logic [DATA_W-1:0]  st_wdata;
  logic [STRB_W-1:0]  st_wstrb;

  modport master (
    output ld_valid, ld_addr, ld_tag, ld_resp_ready, st_valid, st_addr, st_wdata, st_wstrb,
    input  ld_ready, ld_resp_valid, ld_resp_tag, ld_resp_data, ld_resp_err, st_ready
  );

  modport slave (
    input  ld_valid, ld_addr, ld_tag, ld_resp_ready, st_valid, st_addr, st_wdata, st_wstrb,
    output ld_ready, ld_resp_valid, ld_resp_tag, ld_resp_data, ld_resp_err, st_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; head is presented combinationally, DEPTH must be a power of 2.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic             full, do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  assign count   = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Scratchpad responder for the core's data-memory port: fixed-latency tagged loads,
// byte-strobed stores, in-order load responses buffered against core backpressure.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int unsigned MEM_SIZE_KB     = 64,
  parameter int unsigned LD_LATENCY      = 2,
  parameter int unsigned ST_LATENCY      = 2,
  parameter int unsigned RESP_FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  dmem_responder_if.slave bus
);

  localparam int unsigned DEPTH     = MEM_SIZE_KB * 128;
  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam int unsigned MEM_BYTES = MEM_SIZE_KB * 1024;
  localparam int unsigned CNT_W     = $clog2(RESP_FIFO_DEPTH + 1);
  localparam int unsigned CRED_W    = $clog2(RESP_FIFO_DEPTH + LD_LATENCY + 1);
  localparam int unsigned RESP_W    = $bits(ld_resp_t);

  typedef struct packed {
    logic              valid;
    logic              oor;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } st_stage_t;

  typedef struct packed {
    logic     valid;
    ld_resp_t resp;
  } ld_stage_t;

  logic [DATA_W-1:0] mem [DEPTH];

  ld_req_t           ld_req;
  st_req_t           st_req;
  logic [IDX_W-1:0]  ld_idx, st_idx;
  logic              ld_oor, st_oor;
  logic              ld_en, ld_ready, ld_acc, st_acc, hazard, credit_ok;
  logic              pop, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [CRED_W-1:0] pipe_cnt;
  st_stage_t         st_q [ST_LATENCY];
  st_stage_t         st_out;
  ld_stage_t         ld_in, push_e;
  ld_resp_t          head;

  assign ld_req = '{addr: bus.ld_addr, tag: bus.ld_tag};
  assign st_req = '{addr: bus.st_addr, wdata: bus.st_wdata, wstrb: bus.st_wstrb};
  assign ld_idx = IDX_W'(dw_index(ld_req.addr));
  assign st_idx = IDX_W'(dw_index(st_req.addr));
  assign ld_oor = (ld_req.addr >= ADDR_W'(MEM_BYTES));
  assign st_oor = (st_req.addr >= ADDR_W'(MEM_BYTES));

  assign bus.st_ready = 1'b1;
  assign st_acc       = bus.st_valid;

  // Loads are held off for the reset cycle itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ld_en <= 1'b0;
    else        ld_en <= 1'b1;
  end

  // A load must not read an index that a pending or same-cycle store will overwrite.
  always_comb begin
    hazard = st_acc && (st_idx == ld_idx);
    for (int i = 0; i < int'(ST_LATENCY); i++)
      if (st_q[i].valid && (st_q[i].idx == ld_idx)) hazard = 1'b1;
  end

  assign credit_ok    = (CRED_W'(fifo_count) + pipe_cnt) < CRED_W'(RESP_FIFO_DEPTH);
  assign ld_ready     = ld_en && credit_ok && !hazard;
  assign ld_acc       = bus.ld_valid && ld_ready;
  assign bus.ld_ready = ld_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ST_LATENCY); i++) st_q[i] <= '0;
    end else begin
      st_q[0] <= '{valid: st_acc, oor: st_oor, idx: st_idx,
                   wdata: st_req.wdata, wstrb: st_req.wstrb};
      for (int i = 1; i < int'(ST_LATENCY); i++) st_q[i] <= st_q[i-1];
    end
  end

  assign st_out = st_q[ST_LATENCY-1];

  // Byte-strobed write at store-pipe exit; contents survive reset.
  always_ff @(posedge clk) begin
    if (st_out.valid && !st_out.oor)
      for (int b = 0; b < int'(STRB_W); b++)
        if (st_out.wstrb[b]) mem[st_out.idx][8*b +: 8] <= st_out.wdata[8*b +: 8];
  end

  always_comb begin
    ld_in.valid     = ld_acc;
    ld_in.resp.tag  = ld_req.tag;
    ld_in.resp.err  = ld_oor;
    ld_in.resp.data = ld_oor ? '0 : mem[ld_idx];
  end

  // Load pipe: LD_LATENCY-1 register stages ahead of the response FIFO.
  if (LD_LATENCY == 1) begin : g_ld_direct
    assign push_e   = ld_in;
    assign pipe_cnt = '0;
  end else begin : g_ld_pipe
    localparam int unsigned NQ = LD_LATENCY - 1;
    ld_stage_t ld_q [NQ];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(NQ); i++) ld_q[i] <= '0;
      end else begin
        ld_q[0] <= ld_in;
        for (int i = 1; i < int'(NQ); i++) ld_q[i] <= ld_q[i-1];
      end
    end

    always_comb begin
      pipe_cnt = '0;
      for (int i = 0; i < int'(NQ); i++) pipe_cnt = pipe_cnt + CRED_W'(ld_q[i].valid);
    end

    assign push_e = ld_q[NQ-1];
  end

  assign pop = !fifo_empty && bus.ld_resp_ready;

  sync_fifo #(
    .WIDTH (RESP_W),
    .DEPTH (RESP_FIFO_DEPTH)
  ) u_resp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_e.valid),
    .wdata (push_e.resp),
    .pop   (pop),
    .rdata (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.ld_resp_valid = !fifo_empty;
  assign bus.ld_resp_tag   = head.tag;
  assign bus.ld_resp_data  = head.data;
  assign bus.ld_resp_err   = head.err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: store/load data paths, strobes, hazards,
// response backpressure, out-of-range accesses and mid-flight reset.
module tb_dmem_responder;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  dmem_responder_if bus ();

  dmem_responder u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_wdata = d;
    bus.st_wstrb = s;
    @(posedge clk);
    #1;
    bus.st_valid = 1'b0;
  endtask

  // Presents a load until accepted; waited = stall cycles before acceptance.
  task automatic issue_load(input logic [31:0] a, input logic [3:0] t, output int waited);
    bus.ld_addr  = a;
    bus.ld_tag   = t;
    bus.ld_valid = 1'b1;
    waited = 0;
    #1;
    while (!bus.ld_ready && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!bus.ld_ready) chk("ld_accept_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    bus.ld_valid = 1'b0;
  endtask

  task automatic expect_resp(input string tg, input logic [3:0] t, input logic [63:0] d,
                             input logic e);
    int n;
    n = 0;
    while (!bus.ld_resp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tg, "_valid"}, 64'(bus.ld_resp_valid), 64'(1));
    chk({tg, "_tag"},   64'(bus.ld_resp_tag),   64'(t));
    chk({tg, "_data"},  bus.ld_resp_data,       d);
    chk({tg, "_err"},   64'(bus.ld_resp_err),   64'(e));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int acc;
    logic hit;
    logic seen;

    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_tag   = '0;
    bus.ld_resp_ready = 1'b1;
    bus.st_valid = 1'b0;
    bus.st_addr  = '0;
    bus.st_wdata = '0;
    bus.st_wstrb = '0;

    idle(2);
    chk("rst_ld_ready",   64'(bus.ld_ready),      64'(0));
    chk("rst_resp_valid", 64'(bus.ld_resp_valid), 64'(0));
    chk("rst_resp_tag",   64'(bus.ld_resp_tag),   64'(0));
    chk("rst_resp_data",  bus.ld_resp_data,       64'(0));
    chk("rst_resp_err",   64'(bus.ld_resp_err),   64'(0));
    chk("rst_st_ready",   64'(bus.st_ready),      64'(1));
    rst_n = 1'b1;
    idle(1);
    chk("post_rst_ld_ready", 64'(bus.ld_ready), 64'(1));

    // 1: full store then load, exact latency
    do_store(32'h0000_0100, 64'h1122_3344_5566_7788, 8'hFF);
    idle(5);
    issue_load(32'h0000_0100, 4'd3, w);
    chk("t1_stall", 64'(w), 64'(0));
    chk("t1_early_valid", 64'(bus.ld_resp_valid), 64'(0));
    idle(1);
    chk("t1_on_time_valid", 64'(bus.ld_resp_valid), 64'(1));
    expect_resp("t1", 4'd3, 64'h1122_3344_5566_7788, 1'b0);

    // 2: low-half strobed store merges with existing bytes
    do_store(32'h0000_0100, 64'hFFFF_FFFF_AAAA_AAAA, 8'h0F);
    idle(5);
    issue_load(32'h0000_0100, 4'd4, w);
    expect_resp("t2", 4'd4, 64'h1122_3344_AAAA_AAAA, 1'b0);

    // 3: load right behind a store to the same doubleword stalls until it retires
    do_store(32'h0000_0200, 64'hCAFE_F00D_1234_5678, 8'hFF);
    issue_load(32'h0000_0204, 4'd5, w);
    chk("t3_stall", 64'(w), 64'(2));
    expect_resp("t3", 4'd5, 64'hCAFE_F00D_1234_5678, 1'b0);

    // same-cycle store and load to one index: store wins, load waits
    bus.st_valid = 1'b1;
    bus.st_addr  = 32'h0000_0300;
    bus.st_wdata = 64'h0BAD_BEEF_0000_0300;
    bus.st_wstrb = 8'hFF;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 32'h0000_0300;
    bus.ld_tag   = 4'd6;
    #1;
    chk("same_cyc_ld_ready", 64'(bus.ld_ready), 64'(0));
    chk("same_cyc_st_ready", 64'(bus.st_ready), 64'(1));
    @(posedge clk);
    #1;
    bus.st_valid = 1'b0;
    issue_load(32'h0000_0300, 4'd6, w);
    chk("same_cyc_stall", 64'(w), 64'(2));
    expect_resp("same_cyc", 4'd6, 64'h0BAD_BEEF_0000_0300, 1'b0);

    // 4: backpressure limits accepted loads to the FIFO depth
    bus.ld_resp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      bus.ld_valid = (acc < 6);
      bus.ld_addr  = 32'h0000_0100;
      bus.ld_tag   = 4'(acc);
      #1;
      hit = bus.ld_valid && bus.ld_ready;
      @(posedge clk);
      #1;
      if (hit) acc++;
    end
    bus.ld_valid = 1'b0;
    chk("t4_accepted", 64'(acc), 64'(4));
    chk("t4_hold_valid", 64'(bus.ld_resp_valid), 64'(1));
    chk("t4_hold_tag", 64'(bus.ld_resp_tag), 64'(0));
    bus.ld_resp_ready = 1'b1;
    for (int k = 0; k < 4; k++)
      expect_resp($sformatf("t4_r%0d", k), 4'(k), 64'h1122_3344_AAAA_AAAA, 1'b0);
    chk("t4_drained", 64'(bus.ld_resp_valid), 64'(0));

    // 5: out-of-range load errors; out-of-range store leaves aliased index alone
    do_store(32'h0000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF);
    idle(4);
    do_store(32'h0001_0000, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF);
    idle(4);
    issue_load(32'h0001_0000, 4'd9, w);
    expect_resp("t5_oor", 4'd9, 64'h0, 1'b1);
    issue_load(32'h0000_0000, 4'd10, w);
    expect_resp("t5_alias", 4'd10, 64'h0123_4567_89AB_CDEF, 1'b0);

    // 6: reset with loads and a store in flight
    do_store(32'h0000_0400, 64'hA5A5_A5A5_5A5A_5A5A, 8'hFF);
    idle(4);
    bus.st_valid = 1'b1;
    bus.st_addr  = 32'h0000_0400;
    bus.st_wdata = 64'h7777_7777_7777_7777;
    bus.st_wstrb = 8'hFF;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 32'h0000_0100;
    bus.ld_tag   = 4'd7;
    #1;
    chk("t6_ld0_ready", 64'(bus.ld_ready), 64'(1));
    @(posedge clk);
    #1;
    bus.st_valid = 1'b0;
    bus.ld_addr  = 32'h0000_0108;
    bus.ld_tag   = 4'd8;
    #1;
    chk("t6_ld1_ready", 64'(bus.ld_ready), 64'(1));
    @(posedge clk);
    #1;
    bus.ld_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(bus.ld_resp_valid), 64'(0));
    chk("t6_rst_ld_ready", 64'(bus.ld_ready), 64'(0));
    idle(2);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.ld_resp_valid) seen = 1'b1;
    end
    chk("t6_no_resp", 64'(seen), 64'(0));
    issue_load(32'h0000_0400, 4'd11, w);
    expect_resp("t6_readback", 4'd11, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
